// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] ErrData    = 32'hDEADBEEF;
  localparam int          MaxLatency = 15;

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous storage with per-byte write enables; contents survive reset.
module dmem_sram #(
  parameter int DWidth = 32,
  parameter int Depth  = 1024,
  parameter int AW     = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              wr_i,
  input  logic [DWidth/8-1:0] be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DWidth-1:0] wdata_i,
  output logic [DWidth-1:0] rdata_o
);

  logic [DWidth-1:0] r_mem [Depth];
  logic [DWidth-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (wr_i) begin
        for (int b = 0; b < DWidth/8; b++) begin
          if (be_i[b]) r_mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        r_rdata <= r_mem[addr_i];
      end
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency memory responder: decodes/faults the request, commits writes as RESP
// begins, and presents the registered response one cycle later.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int                DWidth   = 32,
  parameter int                Depth    = 1024,
  parameter logic [DWidth-1:0] BaseAddr = DWidth'(32'h00004000),
  parameter int                Latency  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                write_i,
  input  logic [DWidth-1:0]   addr_i,
  input  logic [DWidth-1:0]   wdata_i,
  input  logic [DWidth/8-1:0] wstrb_i,
  output logic                ready_o,
  output logic [DWidth-1:0]   rdata_o,
  output logic                err_o,
  output logic [31:0]         rd_cnt_o,
  output logic [31:0]         wr_cnt_o
);

  localparam int          SW    = DWidth / 8;
  localparam int          AW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int          LatC  = (Latency > MaxLatency) ? MaxLatency : Latency;
  localparam logic [3:0]  LatM1 = 4'(LatC - 1);

  state_e              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_write, r_fault;
  logic [AW-1:0]       r_idx;
  logic [DWidth-1:0]   r_wdata;
  logic [SW-1:0]       r_wstrb;
  logic                r_ready, r_err;
  logic [DWidth-1:0]   r_rdata;
  logic [31:0]         r_rd_cnt, r_wr_cnt;

  logic [DWidth-1:0]   w_off;
  logic                w_fault;
  logic                w_accept;
  logic                w_sram_en, w_sram_wr;
  logic [AW-1:0]       w_sram_idx;
  logic [DWidth-1:0]   w_sram_wdata, w_sram_q;
  logic [SW-1:0]       w_sram_be;

  assign w_off   = addr_i - BaseAddr;
  assign w_fault = (addr_i[1:0] != 2'b00) || (addr_i < BaseAddr) ||
                   ((w_off >> 2) >= DWidth'(Depth));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_i) w_next = (LatC == 1) ? RESP : WAIT;
      WAIT:    if (r_cnt == 4'd1) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Reads sample storage at acceptance; writes commit on the edge entering RESP,
  // which for Latency=1 is the acceptance edge itself, so inputs feed the array directly.
  always_comb begin
    w_accept     = 1'b0;
    w_sram_en    = 1'b0;
    w_sram_wr    = 1'b0;
    w_sram_idx   = r_idx;
    w_sram_wdata = r_wdata;
    w_sram_be    = r_wstrb;
    case (r_state)
      IDLE: if (req_i) begin
        w_accept   = 1'b1;
        w_sram_idx = w_off[AW+1:2];
        if (!write_i) begin
          w_sram_en = !w_fault;
        end else if (LatC == 1 && !w_fault) begin
          w_sram_en    = 1'b1;
          w_sram_wr    = 1'b1;
          w_sram_wdata = wdata_i;
          w_sram_be    = wstrb_i;
        end
      end
      WAIT: if (r_cnt == 4'd1 && r_write && !r_fault) begin
        w_sram_en = 1'b1;
        w_sram_wr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_fault  <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      if (w_accept) begin
        r_write <= write_i;
        r_fault <= w_fault;
        r_idx   <= w_off[AW+1:2];
        r_wdata <= wdata_i;
        r_wstrb <= wstrb_i;
        r_cnt   <= LatM1;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == RESP) begin
        r_ready <= 1'b1;
        r_err   <= r_fault;
        if (!r_write) r_rdata <= r_fault ? DWidth'(ErrData) : w_sram_q;
        if (!r_fault) begin
          if (r_write) r_wr_cnt <= r_wr_cnt + 32'd1;
          else         r_rd_cnt <= r_rd_cnt + 32'd1;
        end
      end
    end
  end

  dmem_sram #(
    .DWidth (DWidth),
    .Depth  (Depth),
    .AW     (AW)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (w_sram_en & ~rst_i),
    .wr_i    (w_sram_wr),
    .be_i    (w_sram_be),
    .addr_i  (w_sram_idx),
    .wdata_i (w_sram_wdata),
    .rdata_o (w_sram_q)
  );

  assign ready_o  = r_ready;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;
  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: data path, strobes, faults, reset and latency sweep.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ready, err;
  logic [31:0] rdata, rdc, wrc;

  logic        sreq = 1'b0;
  logic        s_rdy [3];
  logic        s_err [3];
  logic [31:0] s_rdata [3];
  logic [31:0] s_rdc [3];
  logic [31:0] s_wrc [3];

  int total = 0, passed = 0;

  always #5 clk = ~clk;

  dmem_responder #(.Latency(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .write_i(wr), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb), .ready_o(ready), .rdata_o(rdata),
    .err_o(err), .rd_cnt_o(rdc), .wr_cnt_o(wrc));

  dmem_responder #(.Latency(1)) u_s1 (
    .clk_i(clk), .rst_i(rst), .req_i(sreq), .write_i(1'b0), .addr_i(32'h4000),
    .wdata_i(32'h0), .wstrb_i(4'h0), .ready_o(s_rdy[0]), .rdata_o(s_rdata[0]),
    .err_o(s_err[0]), .rd_cnt_o(s_rdc[0]), .wr_cnt_o(s_wrc[0]));

  dmem_responder #(.Latency(2)) u_s2 (
    .clk_i(clk), .rst_i(rst), .req_i(sreq), .write_i(1'b0), .addr_i(32'h4000),
    .wdata_i(32'h0), .wstrb_i(4'h0), .ready_o(s_rdy[1]), .rdata_o(s_rdata[1]),
    .err_o(s_err[1]), .rd_cnt_o(s_rdc[1]), .wr_cnt_o(s_wrc[1]));

  dmem_responder #(.Latency(7)) u_s7 (
    .clk_i(clk), .rst_i(rst), .req_i(sreq), .write_i(1'b0), .addr_i(32'h4000),
    .wdata_i(32'h0), .wstrb_i(4'h0), .ready_o(s_rdy[2]), .rdata_o(s_rdata[2]),
    .err_o(s_err[2]), .rd_cnt_o(s_rdc[2]), .wr_cnt_o(s_wrc[2]));

  // Drive one request from a negedge, return the response and accept-to-ready latency.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic e,
                     output int lat);
    int  n;
    bit  got;
    n = 0; got = 0; rd = '0; e = 1'b0; lat = -1;
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
    while (!got && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ready) begin got = 1; rd = rdata; e = err; end
    end
    req = 1'b0;
    if (got) lat = n - 1;
    else begin
      total++;
      $display("FAIL txn_timeout addr=%h no ready_o within 20 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ready !== 1'b0) $display("FAIL rst_ready got %b want 0", ready); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata); else passed++;
    total++; if (rdc !== 32'h0 || wrc !== 32'h0)
      $display("FAIL rst_cnt got rd=%0d wr=%0d want 0/0", rdc, wrc); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 32'h4000, 32'h12345678, 4'hF, rd, e, lat);
    total++; if (lat !== 2) $display("FAIL wr_latency got %0d want 2", lat); else passed++;
    total++; if (e !== 1'b0) $display("FAIL wr_err got %b want 0", e); else passed++;
    txn(1'b0, 32'h4000, 32'h0, 4'h0, rd, e, lat);
    total++; if (lat !== 2) $display("FAIL rd_latency got %0d want 2", lat); else passed++;
    total++; if (rd !== 32'h12345678) $display("FAIL rd_data got %h want 12345678", rd); else passed++;
    total++; if (rdc !== 32'd1 || wrc !== 32'd1)
      $display("FAIL wr_rd_cnt got rd=%0d wr=%0d want 1/1", rdc, wrc); else passed++;
    @(negedge clk);
    total++; if (ready !== 1'b0 || rdata !== 32'h0)
      $display("FAIL pulse_width got ready=%b rdata=%h want 0/0", ready, rdata); else passed++;
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 32'h4004, 32'hAABBCCDD, 4'hF, rd, e, lat);
    txn(1'b1, 32'h4004, 32'h11223344, 4'b0101, rd, e, lat);
    txn(1'b0, 32'h4004, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'hAA22CC44) $display("FAIL strobe_data got %h want AA22CC44", rd); else passed++;
    txn(1'b1, 32'h4004, 32'hFFFFFFFF, 4'h0, rd, e, lat);
    txn(1'b0, 32'h4004, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'hAA22CC44) $display("FAIL strobe0_data got %h want AA22CC44", rd); else passed++;
    total++; if (wrc !== 32'd4 || rdc !== 32'd3)
      $display("FAIL strobe_cnt got rd=%0d wr=%0d want 3/4", rdc, wrc); else passed++;
    txn(1'b1, 32'h4FFC, 32'h5A5A5A5A, 4'hF, rd, e, lat);
    txn(1'b0, 32'h4FFC, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h5A5A5A5A || e !== 1'b0)
      $display("FAIL last_word got %h err=%b want 5A5A5A5A err=0", rd, e); else passed++;
  endtask

  task automatic test_faults();
    logic [31:0] fa [3];
    logic [31:0] rd; logic e; int lat;
    fa[0] = 32'h3FFC; fa[1] = 32'h4002; fa[2] = 32'h5000;
    for (int i = 0; i < 3; i++) begin
      txn(1'b0, fa[i], 32'h0, 4'h0, rd, e, lat);
      total++; if (e !== 1'b1 || rd !== 32'hDEADBEEF)
        $display("FAIL fault_rd addr=%h got err=%b data=%h want 1/DEADBEEF", fa[i], e, rd);
      else passed++;
    end
    total++; if (wrc !== 32'd5 || rdc !== 32'd4)
      $display("FAIL fault_cnt got rd=%0d wr=%0d want 4/5", rdc, wrc); else passed++;
    txn(1'b1, 32'h4001, 32'hFFFFFFFF, 4'hF, rd, e, lat);
    total++; if (e !== 1'b1) $display("FAIL fault_wr_err got %b want 1", e); else passed++;
    txn(1'b0, 32'h4000, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h12345678) $display("FAIL fault_wr_keep got %h want 12345678", rd); else passed++;
    total++; if (wrc !== 32'd5 || rdc !== 32'd5)
      $display("FAIL fault_wr_cnt got rd=%0d wr=%0d want 5/5", rdc, wrc); else passed++;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; logic e; int lat; int highs;
    txn(1'b1, 32'h4008, 32'h01020304, 4'hF, rd, e, lat);
    req = 1'b1; wr = 1'b1; addr = 32'h4008; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      if (ready) highs++;
      @(negedge clk);
    end
    total++; if (highs !== 0) $display("FAIL mid_rst_ready got %0d pulses want 0", highs); else passed++;
    total++; if (wrc !== 32'd0 || rdc !== 32'd0)
      $display("FAIL mid_rst_cnt got rd=%0d wr=%0d want 0/0", rdc, wrc); else passed++;
    txn(1'b0, 32'h4008, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h01020304) $display("FAIL mid_rst_mem got %h want 01020304", rd); else passed++;
    total++; if (rdc !== 32'd1) $display("FAIL mid_rst_rdcnt got %0d want 1", rdc); else passed++;
  endtask

  task automatic test_back_to_back();
    int lats [3];
    int mism [3];
    int pulses [3];
    lats[0] = 1; lats[1] = 2; lats[2] = 7;
    for (int i = 0; i < 3; i++) begin mism[i] = 0; pulses[i] = 0; end
    sreq = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (s_rdy[i] !== ((n % (lats[i] + 1)) == 0)) mism[i]++;
        if (s_rdy[i] === 1'b1) pulses[i]++;
      end
    end
    sreq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (mism[i] !== 0)
        $display("FAIL sweep_pattern lat=%0d got %0d off-cycle samples want 0", lats[i], mism[i]);
      else passed++;
      total++; if (pulses[i] !== 60 / (lats[i] + 1))
        $display("FAIL sweep_pulses lat=%0d got %0d want %0d", lats[i], pulses[i], 60 / (lats[i] + 1));
      else passed++;
      total++; if (s_rdc[i] !== 32'(60 / (lats[i] + 1)))
        $display("FAIL sweep_rdcnt lat=%0d got %0d want %0d", lats[i], s_rdc[i], 60 / (lats[i] + 1));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_write_read();
    test_strobe();
    test_faults();
    test_reset_mid_write();
    @(negedge clk);
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
